// File: rtl/block_update_engine.sv
`default_nettype none
// ============================================================================
// Module   : block_update_engine
// Purpose  : Handshaked tile-update engine. It reads the tile the player
//            touched, applies the collect/break rules, writes the result back
//            and keeps a saturating score.
// Options  : BLOCK_COMBO_EN enables the combo multiplier and its gap counter.
// Revision : 1.0 - initial release
// ============================================================================
module block_update_engine #(
    parameter int BLOCK_W   = 6,
    parameter int X_W       = 10,
    parameter int Y_W       = 9,
    parameter int TILE_PX   = 40,
    parameter int MAP_COLS  = 16,
    parameter int MAP_ROWS  = 12,
    parameter int ADDR_W    = 8,
    parameter int SCORE_W   = 16,
    parameter int COMBO_GAP = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [X_W-1:0]     req_xpos,
    input  logic [Y_W-1:0]     req_ypos,
    input  logic               req_dir,
    input  logic               req_up,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               mem_rd_en,
    input  logic [BLOCK_W-1:0] mem_rd_data,
    output logic               mem_we,
    output logic [BLOCK_W-1:0] mem_wr_data,
    input  logic               score_clr,
    output logic [SCORE_W-1:0] score,
    output logic               new_point,
    output logic               done,
    output logic               oob,
    output logic [1:0]         combo_level
);

    if ((MAP_COLS * MAP_ROWS > (2 ** ADDR_W)) || (COMBO_GAP < 1)) begin : g_cfg_check
        $error("block_update_engine: ADDR_W cannot address the map or COMBO_GAP < 1");
    end

    localparam logic [BLOCK_W-1:0] c_tile_b  = BLOCK_W'(0);
    localparam logic [BLOCK_W-1:0] c_tile_d  = BLOCK_W'(3);
    localparam logic [BLOCK_W-1:0] c_tile_j  = BLOCK_W'(9);
    localparam logic [BLOCK_W-1:0] c_tile_gy = BLOCK_W'(28);
    localparam logic [BLOCK_W-1:0] c_tile_dy = BLOCK_W'(34);

    localparam logic [X_W-1:0]     c_tile_px_x = X_W'(TILE_PX);
    localparam logic [X_W-1:0]     c_half_px_x = X_W'(TILE_PX / 2);
    localparam logic [X_W-1:0]     c_cols_x    = X_W'(MAP_COLS);
    localparam logic [Y_W-1:0]     c_tile_px_y = Y_W'(TILE_PX);
    localparam logic [Y_W-1:0]     c_rows_y    = Y_W'(MAP_ROWS);
    localparam logic [SCORE_W-1:0] c_score_max = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_EVAL  = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [X_W-1:0]     w_col;
    logic [X_W-1:0]     w_xrem;
    logic [Y_W-1:0]     w_row;
    logic [ADDR_W-1:0]  w_addr;
    logic               w_oob;
    logic               w_half_ok;
    logic               w_accept;
    logic               w_write;
    logic               w_award;

    logic [ADDR_W-1:0]  r_addr;
    logic               r_oob;
    logic               r_half_ok;
    logic               r_up;
    logic               r_do_write;
    logic [BLOCK_W-1:0] r_wr_data;
    logic               r_point;

    logic [SCORE_W-1:0] r_score;
    logic [SCORE_W-1:0] w_inc;
    logic [SCORE_W:0]   w_score_sum;
    logic [SCORE_W-1:0] w_score_sat;

    // Map coordinates of the contact point; divisors are constants.
    assign w_col     = req_xpos / c_tile_px_x;
    assign w_xrem    = req_xpos % c_tile_px_x;
    assign w_row     = req_ypos / c_tile_px_y;
    assign w_oob     = (w_col >= c_cols_x) || (w_row >= c_rows_y);
    assign w_half_ok = req_dir ? (w_xrem >= c_half_px_x) : (w_xrem < c_half_px_x);
    assign w_addr    = ADDR_W'(w_row) * ADDR_W'(MAP_COLS) + ADDR_W'(w_col);
    assign w_accept  = (r_state == S_IDLE) && req_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        req_ready    = 1'b0;
        mem_rd_en    = 1'b0;
        w_write      = 1'b0;
        done         = 1'b0;
        new_point    = 1'b0;
        oob          = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_state_next = w_oob ? S_WRITE : S_READ;
                end
            end
            S_READ: begin
                mem_rd_en    = 1'b1;
                w_state_next = S_EVAL;
            end
            S_EVAL: begin
                w_state_next = S_WRITE;
            end
            S_WRITE: begin
                w_write      = r_do_write;
                done         = 1'b1;
                new_point    = r_point;
                oob          = r_oob;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign mem_addr    = r_addr;
    assign mem_we      = w_write;
    assign mem_wr_data = w_write ? r_wr_data : c_tile_b;

    // Out-of-map requests keep the previous address so mem_addr never glitches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr     <= '0;
            r_oob      <= 1'b0;
            r_half_ok  <= 1'b0;
            r_up       <= 1'b0;
            r_do_write <= 1'b0;
            r_wr_data  <= c_tile_b;
            r_point    <= 1'b0;
        end else if (w_accept) begin
            if (!w_oob) begin
                r_addr <= w_addr;
            end
            r_oob      <= w_oob;
            r_half_ok  <= w_half_ok;
            r_up       <= req_up;
            r_do_write <= 1'b0;
            r_wr_data  <= c_tile_b;
            r_point    <= 1'b0;
        end else if (r_state == S_EVAL) begin
            r_do_write <= 1'b0;
            r_wr_data  <= c_tile_b;
            r_point    <= 1'b0;
            if (mem_rd_data == c_tile_gy) begin
                r_do_write <= 1'b1;
                r_point    <= 1'b1;
            end else if ((mem_rd_data == c_tile_d) && r_half_ok && r_up) begin
                r_do_write <= 1'b1;
                r_wr_data  <= c_tile_dy;
                r_point    <= 1'b1;
            end else if ((mem_rd_data == c_tile_j) && r_half_ok && r_up) begin
                r_do_write <= 1'b1;
            end
        end
    end

    assign w_award = (r_state == S_WRITE) && r_point;

`ifdef BLOCK_COMBO_EN
    localparam int c_gap_w = $clog2(COMBO_GAP + 2);
    localparam logic [c_gap_w-1:0] c_gap_sat = c_gap_w'(COMBO_GAP + 1);
    localparam logic [c_gap_w-1:0] c_gap_lim = c_gap_w'(COMBO_GAP);

    logic [c_gap_w-1:0] r_gap;
    logic [1:0]         r_combo;
    logic [1:0]         w_combo_next;

    // r_gap holds the distance in cycles to the last point, parked at
    // c_gap_sat when no recent point exists (after reset or clear).
    always_comb begin
        w_combo_next = 2'd0;
        if (r_gap <= c_gap_lim) begin
            w_combo_next = (r_combo == 2'd3) ? 2'd3 : r_combo + 2'd1;
        end
    end

    assign w_inc = SCORE_W'(w_combo_next) + SCORE_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gap   <= c_gap_sat;
            r_combo <= 2'd0;
        end else if (score_clr) begin
            r_gap   <= c_gap_sat;
            r_combo <= 2'd0;
        end else if (w_award) begin
            r_gap   <= c_gap_w'(1);
            r_combo <= w_combo_next;
        end else if (r_gap != c_gap_sat) begin
            r_gap <= r_gap + c_gap_w'(1);
        end
    end

    assign combo_level = r_combo;
`else
    assign w_inc       = SCORE_W'(1);
    assign combo_level = 2'd0;
`endif

    assign w_score_sum = {1'b0, r_score} + {1'b0, w_inc};
    assign w_score_sat = w_score_sum[SCORE_W] ? c_score_max : w_score_sum[SCORE_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_score <= '0;
        end else if (score_clr) begin
            r_score <= '0;
        end else if (w_award) begin
            r_score <= w_score_sat;
        end
    end

    assign score = r_score;

endmodule
`default_nettype wire

// File: tb/tb_block_update_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_block_update_engine
// Purpose  : Self-checking bench for block_update_engine with a tile RAM model
//            and a score/combo reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_block_update_engine;

    // A narrow score keeps saturation reachable in a short run.
    localparam int SW    = 6;
    localparam int SMAX  = (1 << SW) - 1;
    localparam int CGAP  = 64;
    localparam int TILE  = 40;
    localparam int COLS  = 16;
    localparam int ROWS  = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid, req_ready, req_dir, req_up;
    logic [9:0]    req_xpos;
    logic [8:0]    req_ypos;
    logic [7:0]    mem_addr;
    logic          mem_rd_en, mem_we;
    logic [5:0]    mem_rd_data, mem_wr_data;
    logic          score_clr, new_point, done, oob;
    logic [SW-1:0] score;
    logic [1:0]    combo_level;

    block_update_engine #(.SCORE_W(SW), .COMBO_GAP(CGAP)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_xpos(req_xpos), .req_ypos(req_ypos), .req_dir(req_dir), .req_up(req_up),
        .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rd_data(mem_rd_data),
        .mem_we(mem_we), .mem_wr_data(mem_wr_data),
        .score_clr(score_clr), .score(score), .new_point(new_point),
        .done(done), .oob(oob), .combo_level(combo_level)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Tile RAM: one-cycle read latency; poke port preloads tiles while idle.
    logic [5:0] ram [0:255];
    logic       poke = 1'b0;
    logic [7:0] poke_addr = '0;
    logic [5:0] poke_data = '0;
    always @(posedge clk) begin
        if (poke) ram[poke_addr] <= poke_data;
        else if (mem_we) ram[mem_addr] <= mem_wr_data;
        if (mem_rd_en) mem_rd_data <= ram[mem_addr];
    end

    typedef struct {
        int tile; int x; int y; bit dir; bit up;
        bit oob; bit we; int wd; bit pt; int addr;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;
    int last_sc, last_cl;

    // Reference score/combo state.
    int m_score, m_lvl, m_last;
    bit m_have;

    function automatic void m_clear();
        m_score = 0; m_lvl = 0; m_have = 1'b0; m_last = 0;
    endfunction

    function automatic void m_point(input int wc);
        int inc;
`ifdef BLOCK_COMBO_EN
        if (m_have && (wc - m_last) <= CGAP) m_lvl = (m_lvl == 3) ? 3 : m_lvl + 1;
        else m_lvl = 0;
        inc = m_lvl + 1;
`else
        inc = 1;
`endif
        m_score = (m_score + inc > SMAX) ? SMAX : m_score + inc;
        m_have  = 1'b1;
        m_last  = wc;
    endfunction

    function automatic vec_t predict(input int tile, input int x, input int y,
                                     input bit dir, input bit up);
        vec_t v;
        int col, row, r;
        bit half;
        v.tile = tile; v.x = x; v.y = y; v.dir = dir; v.up = up;
        col = x / TILE; row = y / TILE; r = x % TILE;
        v.oob  = (col >= COLS) || (row >= ROWS);
        v.addr = v.oob ? 0 : row * COLS + col;
        half   = dir ? (r >= TILE / 2) : (r < TILE / 2);
        v.we = 1'b0; v.pt = 1'b0; v.wd = 0;
        if (!v.oob) begin
            if (tile == 28) begin
                v.we = 1'b1; v.pt = 1'b1;
            end else if (tile == 3 && half && up) begin
                v.we = 1'b1; v.wd = 34; v.pt = 1'b1;
            end else if (tile == 9 && half && up) begin
                v.we = 1'b1;
            end
        end
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic poke_tile(input int a, input int d);
        poke = 1'b1; poke_addr = a[7:0]; poke_data = d[5:0];
        @(negedge clk);
        poke = 1'b0;
    endtask

    // Starts and ends on a negedge with the engine idle; score_clr is raised
    // during cycle clr_at (1..3) of the request when nonzero.
    task automatic run_vec(input vec_t v, input int clr_at, input bit do_poke,
                           input string tag);
        logic [3:0] rd, we, dn, ob, np, rdy;
        int a_rd, a_wr, wd, wcyc;
        if (do_poke && !v.oob) poke_tile(v.addr, v.tile);
        req_xpos = 10'(v.x); req_ypos = 9'(v.y);
        req_dir = v.dir; req_up = v.up; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        a_rd = 0; a_wr = 0; wd = 0; wcyc = 0;
        for (int c = 0; c < 4; c++) begin
            rd[c] = mem_rd_en; we[c] = mem_we; dn[c] = done;
            ob[c] = oob; np[c] = new_point; rdy[c] = req_ready;
            if (c == 0) a_rd = mem_addr;
            if (c == 2) begin a_wr = mem_addr; wd = mem_wr_data; wcyc = cyc; end
            if (c == 3) begin last_sc = score; last_cl = combo_level; end
            score_clr = (clr_at == c + 1);
            if (c < 3) @(negedge clk);
        end
        score_clr = 1'b0;
        if (clr_at == 1 || clr_at == 2) m_clear();
        if (v.pt) m_point(wcyc);
        if (clr_at == 3) m_clear();
        chk({tag, "/rd_en"},     rd,  v.oob ? 0 : 1);
        chk({tag, "/mem_we"},    we,  v.we ? 4 : 0);
        chk({tag, "/done"},      dn,  v.oob ? 1 : 4);
        chk({tag, "/oob"},       ob,  v.oob ? 1 : 0);
        chk({tag, "/new_point"}, np,  v.pt ? 4 : 0);
        chk({tag, "/req_ready"}, rdy, v.oob ? 14 : 8);
        if (!v.oob) chk({tag, "/rd_addr"}, a_rd, v.addr);
        if (v.we) begin
            chk({tag, "/wr_addr"}, a_wr, v.addr);
            chk({tag, "/wr_data"}, wd, v.wd);
        end
        chk({tag, "/score"}, last_sc, m_score);
        chk({tag, "/combo"}, last_cl, m_lvl);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t tbl[14];

    initial begin
        vec_t v;
        int   anyw, anyd, clr_at, sel, tile;
        //        tile  x    y   dir up  oob we wd  pt addr
        tbl[0]  = '{28,  45,  85, 1, 0,  0, 1, 0,  1, 33};
        tbl[1]  = '{3,   45,  85, 0, 1,  0, 1, 34, 1, 33};
        tbl[2]  = '{3,   45,  85, 1, 1,  0, 0, 0,  0, 33};
        tbl[3]  = '{9,   45,  85, 0, 1,  0, 1, 0,  0, 33};
        tbl[4]  = '{9,   45,  85, 0, 0,  0, 0, 0,  0, 33};
        tbl[5]  = '{28,  700, 85, 0, 0,  1, 0, 0,  0, 0};
        tbl[6]  = '{3,   39,  0,  1, 1,  0, 1, 34, 1, 0};
        tbl[7]  = '{3,   20,  0,  0, 1,  0, 0, 0,  0, 0};
        tbl[8]  = '{28,  639, 479,0, 0,  0, 1, 0,  1, 191};
        tbl[9]  = '{28,  640, 0,  1, 1,  1, 0, 0,  0, 0};
        tbl[10] = '{28,  0,   480,0, 0,  1, 0, 0,  0, 0};
        tbl[11] = '{34,  45,  85, 0, 1,  0, 0, 0,  0, 33};
        tbl[12] = '{3,   59,  0,  0, 1,  0, 1, 34, 1, 1};
        tbl[13] = '{9,   60,  40, 1, 1,  0, 1, 0,  0, 17};

        req_valid = 1'b0; req_xpos = '0; req_ypos = '0;
        req_dir = 1'b0; req_up = 1'b0; score_clr = 1'b0;
        m_clear();

        repeat (3) @(negedge clk);
        chk("reset/req_ready", req_ready, 1);
        chk("reset/score", score, 0);
        chk("reset/strobes", {mem_rd_en, mem_we, done, new_point, oob}, 0);
        chk("reset/mem_addr", mem_addr, 0);
        chk("reset/combo", combo_level, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 14; i++) run_vec(tbl[i], 0, 1'b1, $sformatf("vec%0d", i));

        // Clear coincident with a point wins; clear before the point does not.
        run_vec(predict(28, 45, 85, 0, 0), 3, 1'b1, "clr_win");
        chk("clr_win/score_zero", last_sc, 0);
        run_vec(predict(28, 45, 85, 0, 0), 1, 1'b1, "clr_pre");
        chk("clr_pre/score_one", last_sc, 1);

        // Three back-to-back hits, then one after a long idle stretch.
        score_clr = 1'b1; @(negedge clk); score_clr = 1'b0; m_clear();
        poke_tile(33, 28); poke_tile(34, 28); poke_tile(35, 28);
        run_vec(predict(28, 45, 85, 0, 0), 0, 1'b0, "combo1");
        chk("combo1/score", last_sc, 1);  chk("combo1/level", last_cl, 0);
        run_vec(predict(28, 85, 85, 0, 0), 0, 1'b0, "combo2");
        run_vec(predict(28, 125, 85, 0, 0), 0, 1'b0, "combo3");
`ifdef BLOCK_COMBO_EN
        chk("combo3/score", last_sc, 6);  chk("combo3/level", last_cl, 2);
`else
        chk("combo3/score", last_sc, 3);  chk("combo3/level", last_cl, 0);
`endif
        repeat (70) @(negedge clk);
        run_vec(predict(28, 45, 85, 0, 0), 0, 1'b1, "combo_gap");
`ifdef BLOCK_COMBO_EN
        chk("combo_gap/score", last_sc, 7);
`else
        chk("combo_gap/score", last_sc, 4);
`endif
        chk("combo_gap/level", last_cl, 0);

        // Reset during READ abandons the request.
        poke_tile(33, 28);
        req_xpos = 10'd45; req_ypos = 9'd85; req_dir = 1'b1; req_up = 1'b0;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rst_mid/in_read", mem_rd_en, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_clear();
        chk("rst_mid/req_ready", req_ready, 1);
        chk("rst_mid/score", score, 0);
        anyw = 0; anyd = 0;
        for (int c = 0; c < 6; c++) begin
            anyw |= mem_we; anyd |= done;
            @(negedge clk);
        end
        chk("rst_mid/no_write", anyw, 0);
        chk("rst_mid/no_done", anyd, 0);

        // Drive the score into saturation.
        for (int k = 0; k < SMAX + 6; k++) run_vec(predict(28, 45, 85, 1, 0), 0, 1'b1, "sat");
        chk("sat/score_max", last_sc, SMAX);

        // Randomized requests against the reference model.
        for (int k = 0; k < 250; k++) begin
            sel = $urandom_range(0, 5);
            case (sel)
                0: tile = 0;
                1: tile = 3;
                2: tile = 9;
                3: tile = 28;
                4: tile = 34;
                default: tile = $urandom_range(0, 63);
            endcase
            v = predict(tile, $urandom_range(0, 719), $urandom_range(0, 511),
                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            clr_at = ($urandom_range(0, 19) == 0) ? $urandom_range(1, 3) : 0;
            run_vec(v, clr_at, 1'b1, $sformatf("rnd%0d", k));
            if ($urandom_range(0, 9) == 0) repeat ($urandom_range(50, 80)) @(negedge clk);
            else repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
